cpuc_regfile_rd: RTL and testbench

CPUC_REGFILE_RD -- requirements
Module: cpuc_regfile_rd

---
 rtl/cpuc_package.sv | 20 ++
 rtl/cpuc_rsp_fifo.sv | 80 ++++++++
 rtl/cpuc_regfile_rd.sv | 66 ++++++
 tb/tb_cpuc_regfile_rd.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpuc_package.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpuc_package                                                         |
// | Shared widths and response-queue state type for the register file.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpuc_package;

   localparam int DATA_WIDTH     = 32;
   localparam int NUM_REGS       = 8;
   localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } t_rsp_state;

endpackage
`default_nettype wire

// File: rtl/cpuc_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpuc_rsp_fifo                                                        |
// | Two-entry valid/ready response queue, FIFO order.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpuc_rsp_fifo
   import cpuc_package::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   t_rsp_state       state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             w_push;
   logic             w_pop;

   assign pop_valid  = (state_q != EMPTY);
   assign pop_data   = head_q;
   // A full queue still accepts when its head leaves on the same edge.
   assign push_ready = ~rst & ((state_q != TWO) | (pop_valid & pop_ready));
   assign w_push     = push_valid & push_ready;
   assign w_pop      = pop_valid & pop_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (w_push) begin
               state_d = ONE;
               head_d  = push_data;
            end
         end
         ONE: begin
            if (w_push && w_pop) begin
               head_d = push_data;
            end else if (w_push) begin
               state_d = TWO;
               tail_d  = push_data;
            end else if (w_pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (w_pop) begin
               head_d = tail_q;
               if (w_push) tail_d  = push_data;
               else        state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cpuc_regfile_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpuc_regfile_rd                                                      |
// | Register file with write-first captured reads through a 2-deep queue.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpuc_regfile_rd #(
   parameter  int NUM_REGS       = cpuc_package::NUM_REGS,
   parameter  int DATA_WIDTH     = cpuc_package::DATA_WIDTH,
   localparam int REG_ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_req_valid,
   output logic                      rd_req_ready,
   input  logic [REG_ADDR_WIDTH-1:0] rd_req_addr,
   output logic                      rd_rsp_valid,
   input  logic                      rd_rsp_ready,
   output logic [DATA_WIDTH-1:0]     rd_rsp_data
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] w_rd_val;

   // Entry 0 is a hardwired zero; indices outside the file never match.
   assign regs_q[0] = '0;

   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_regs
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               regs_q[gi] <= '0;
            end else if (wr_en && (wr_addr == REG_ADDR_WIDTH'(gi))) begin
               regs_q[gi] <= wr_data;
            end
         end
      end
   endgenerate

   always_comb begin
      w_rd_val = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rd_req_addr == REG_ADDR_WIDTH'(i)) begin
            w_rd_val = (wr_en && (wr_addr == rd_req_addr)) ? wr_data : regs_q[i];
         end
      end
   end

   cpuc_rsp_fifo #(
      .WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (rd_req_valid),
      .push_ready (rd_req_ready),
      .push_data  (w_rd_val),
      .pop_valid  (rd_rsp_valid),
      .pop_ready  (rd_rsp_ready),
      .pop_data   (rd_rsp_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_cpuc_regfile_rd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpuc_regfile_rd                                                   |
// | Directed and random checks against a queue-based reference model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cpuc_regfile_rd;

   localparam int NR = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_req_valid = 1'b0;
   logic          rd_req_ready;
   logic [2:0]    rd_req_addr = '0;
   logic          rd_rsp_valid;
   logic          rd_rsp_ready = 1'b0;
   logic [DW-1:0] rd_rsp_data;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_q [$];

   cpuc_regfile_rd #(
      .NUM_REGS   (NR),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_addr  (rd_req_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data  (rd_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
   endtask

   // One clock: check outputs mid-cycle, then advance the model on the edge.
   task automatic step();
      logic          exp_rdy;
      logic          req_fire;
      logic          rsp_fire;
      logic [DW-1:0] cap;
      @(negedge clk);
      exp_rdy = (m_q.size() < 2) || rd_rsp_ready;
      chk("req_ready", {31'd0, rd_req_ready}, {31'd0, exp_rdy});
      chk("rsp_valid", {31'd0, rd_rsp_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) chk("rsp_data", rd_rsp_data, m_q[0]);
      req_fire = rd_req_valid && exp_rdy;
      rsp_fire = (m_q.size() != 0) && rd_rsp_ready;
      if (rd_req_addr == 0)                         cap = '0;
      else if (wr_en && (wr_addr == rd_req_addr))   cap = wr_data;
      else                                          cap = m_regs[rd_req_addr];
      @(posedge clk);
      if (rsp_fire) void'(m_q.pop_front());
      if (req_fire) m_q.push_back(cap);
      if (wr_en && (wr_addr != 0)) m_regs[wr_addr] = wr_data;
      #1;
   endtask

   task automatic idle();
      wr_en        = 1'b0;
      rd_req_valid = 1'b0;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = d;
   endtask

   task automatic rq(input int a);
      rd_req_valid = 1'b1;
      rd_req_addr  = 3'(a);
   endtask

   initial begin
      model_clear();
      #12;
      chk("rst_valid", {31'd0, rd_rsp_valid}, 32'd0);
      chk("rst_ready", {31'd0, rd_req_ready}, 32'd0);
      chk("rst_data", rd_rsp_data, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Read after reset, one-cycle latency
      rd_rsp_ready = 1'b1;
      rq(3);
      step();
      idle();
      chk("lat_valid", {31'd0, rd_rsp_valid}, 32'd1);
      chk("lat_data", rd_rsp_data, 32'd0);
      step();

      // Write-first forwarding and register 0
      wr(5, 32'hDEADBEEF); rq(5);
      step();
      idle();
      chk("fwd_data", rd_rsp_data, 32'hDEADBEEF);
      step();
      wr(0, 32'h12345678);
      step();
      idle(); rq(0);
      step();
      idle();
      chk("r0_data", rd_rsp_data, 32'd0);
      step();

      // Backpressure, full queue, immutability of queued data
      wr(1, 32'h11); step();
      wr(2, 32'h22); step();
      wr(3, 32'h33); step();
      idle();
      rd_rsp_ready = 1'b0;
      rq(1); step();
      rq(2); step();
      rq(3);
      chk("full_ready", {31'd0, rd_req_ready}, 32'd0);
      step();
      wr(1, 32'hAA);
      step();
      wr_en = 1'b0;
      chk("immut_head", rd_rsp_data, 32'h11);
      rd_rsp_ready = 1'b1;
      step();
      idle();
      chk("order2", rd_rsp_data, 32'h22);
      step();
      chk("order3", rd_rsp_data, 32'h33);
      step();

      // Back-to-back reads r1..r7
      for (int a = 1; a < NR; a++) begin
         wr(a, 32'hA000_0000 | 32'(a));
         step();
      end
      idle();
      for (int a = 1; a < NR; a++) begin
         rq(a);
         step();
         chk("b2b_valid", {31'd0, rd_rsp_valid}, 32'd1);
      end
      idle();
      step();
      step();

      // Reset while queue holds two entries
      rd_rsp_ready = 1'b0;
      rq(4); step();
      rq(5); step();
      idle();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, rd_rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, rd_req_ready}, 32'd0);
      chk("mid_rst_data", rd_rsp_data, 32'd0);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      rd_rsp_ready = 1'b1;
      for (int a = 0; a < NR; a++) begin
         rq(a);
         step();
      end
      idle();
      step();
      step();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         wr_en        = ($urandom_range(0, 2) == 0);
         wr_addr      = 3'($urandom_range(0, NR - 1));
         wr_data      = $urandom;
         rd_req_valid = ($urandom_range(0, 3) != 0);
         rd_req_addr  = 3'($urandom_range(0, NR - 1));
         rd_rsp_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      idle();
      rd_rsp_ready = 1'b1;
      step();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
